hole_fill: RTL

- Streaming 3x3 neighbourhood filter; the complement of the existing isolated-pixel remover.
- Fills isolated dark pixels (holes): when the centre pixel is zero and all 8 neighbours are non-zero, the centre is replaced by the truncated mean of the 8 neighbours.
- Sits in the CCD capture path, on the same 10-bit, iDVAL-qualified pixel stream as the other stream filters. Contains its own two-line buffer and a per-frame fill counter.

---
 rtl/hole_fill.sv | 134 +++++++++++++
 1 files changed

// File: rtl/hole_fill.sv
// Streaming 3x3 hole filler: a zero pixel whose eight neighbours are all non-zero
// is replaced by their truncated mean. Also keeps a per-frame fill count.
module hole_fill #(
  parameter int LINE_WIDTH = 640,
  parameter int CNT_W      = 20
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic [9:0]       idata,
  input  logic             iDVAL,
  input  logic             iFVAL,
  output logic [9:0]       odata,
  output logic             oDVAL,
  output logic             oFILL,
  output logic [CNT_W-1:0] oFILL_CNT
);
  localparam int COL_W = (LINE_WIDTH > 4) ? $clog2(LINE_WIDTH) : 2;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_WIDTH - 1);

  logic [7:0] lb1_mem [LINE_WIDTH];
  logic [7:0] lb2_mem [LINE_WIDTH];

  logic [COL_W-1:0] col_q, col_eff, col_d;
  logic [1:0]       row_q, row_eff, row_d;
  logic             fval_q;
  logic [2:0][7:0]  d1_q, d2_q, d1_eff, d2_eff, new_col;
  logic [9:0]       odata_q;
  logic             odval_q, ofill_q;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d, fill_cnt_q;

  logic [7:0]  pix, centre, result;
  logic        frame_start, frame_end, col_wrap, complete, fill;
  logic [7:0]  nbr [8];
  logic [7:0]  nz;
  logic [10:0] nbr_sum;
  logic        unused_lsbs;

  assign pix         = idata[9:2];
  assign unused_lsbs = ^idata[1:0];

  assign frame_start = iFVAL & ~fval_q;
  assign frame_end   = ~iFVAL & fval_q;
  assign col_eff     = frame_start ? '0 : col_q;
  assign row_eff     = frame_start ? 2'd0 : row_q;
  assign d1_eff      = frame_start ? '0 : d1_q;
  assign d2_eff      = frame_start ? '0 : d2_q;

  // Rows not yet written in this frame read as zero, as if the buffers were cleared.
  assign new_col[0] = (row_eff == 2'd2) ? lb2_mem[col_eff] : 8'd0;
  assign new_col[1] = (row_eff != 2'd0) ? lb1_mem[col_eff] : 8'd0;
  assign new_col[2] = pix;

  assign centre = d1_eff[1];
  assign nbr[0] = d2_eff[0];
  assign nbr[1] = d2_eff[1];
  assign nbr[2] = d2_eff[2];
  assign nbr[3] = d1_eff[0];
  assign nbr[4] = d1_eff[2];
  assign nbr[5] = new_col[0];
  assign nbr[6] = new_col[1];
  assign nbr[7] = new_col[2];

  for (genvar gi = 0; gi < 8; gi++) begin : g_nz
    assign nz[gi] = |nbr[gi];
  end

  always_comb begin
    nbr_sum = 11'd0;
    for (int i = 0; i < 8; i++) nbr_sum = nbr_sum + {3'b000, nbr[i]};
  end

  assign complete = (row_eff == 2'd2) && (col_eff >= COL_W'(2));
  assign fill     = complete && (centre == 8'd0) && (&nz);
  assign result   = fill ? nbr_sum[10:3] : centre;

  assign col_wrap = (col_eff == COL_LAST);
  assign col_d    = col_wrap ? '0 : col_eff + COL_W'(1);
  assign row_d    = (col_wrap && row_eff != 2'd2) ? row_eff + 2'd1 : row_eff;

  always_comb begin
    run_cnt_d = run_cnt_q;
    if (ofill_q && run_cnt_q != '1) run_cnt_d = run_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      fval_q     <= 1'b0;
      col_q      <= '0;
      row_q      <= 2'd0;
      d1_q       <= '0;
      d2_q       <= '0;
      odata_q    <= 10'd0;
      odval_q    <= 1'b0;
      ofill_q    <= 1'b0;
      run_cnt_q  <= '0;
      fill_cnt_q <= '0;
    end else begin
      fval_q  <= iFVAL;
      odval_q <= iDVAL;
      odata_q <= iDVAL ? {result, 2'b00} : 10'd0;
      ofill_q <= iDVAL & fill;
      if (iDVAL) begin
        col_q <= col_d;
        row_q <= row_d;
        d1_q  <= new_col;
        d2_q  <= d1_eff;
      end else begin
        col_q <= col_eff;
        row_q <= row_eff;
        d1_q  <= d1_eff;
        d2_q  <= d2_eff;
      end
      // A fill emitted on the closing cycle is already folded into run_cnt_d.
      if (frame_end) begin
        fill_cnt_q <= run_cnt_d;
        run_cnt_q  <= '0;
      end else begin
        run_cnt_q <= run_cnt_d;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iDVAL) begin
      lb1_mem[col_eff] <= pix;
      lb2_mem[col_eff] <= new_col[1];
    end
  end

  assign odata     = odata_q;
  assign oDVAL     = odval_q;
  assign oFILL     = ofill_q;
  assign oFILL_CNT = fill_cnt_q;
endmodule
